// File: rtl/clkenb_pkg.sv
// clkenb_pkg: shared types and defaults for the multi-channel clock-enable
// generator (clkenb_multi / clkenb_chan).
package clkenb_pkg;
  localparam int          DIVW_DEF   = 27;                 // covers 1 Hz at 100 MHz
  localparam int          NCH_DEF    = 4;
  localparam int unsigned DEFDIV_DEF = 100_000_000 / 100;  // 100 Hz tick after reset

  typedef logic [DIVW_DEF-1:0] div_t;
  typedef enum logic {IDLE, RUN}     chst_t;
  typedef enum logic {CONT, ONESHOT} mode_t;
endpackage

// File: rtl/clkenb_chan.sv
// clkenb_chan: one enable-generator channel.
//   clk, reset  : system clock, synchronous active-high reset
//   ld          : writes ld_div / ld_mode into the shadow divisor
//   ld_div      : divisor D (period of D cycles, 0 = disabled)
//   ld_mode     : 0 = continuous, 1 = one-shot
//   start, stop : run / halt requests (stop wins)
//   align       : restart the counter at 0 while running
//   enb         : registered single-cycle enable pulse
//   busy        : channel is in RUN
module clkenb_chan
  import clkenb_pkg::*;
#(
  parameter int          DIVW   = DIVW_DEF,
  parameter int unsigned DEFDIV = DEFDIV_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld,
  input  logic [DIVW-1:0] ld_div,
  input  logic            ld_mode,
  input  logic            start,
  input  logic            stop,
  input  logic            align,
  output logic            enb,
  output logic            busy
);

  chst_t           st;
  mode_t           act_mode, shd_mode;
  logic [DIVW-1:0] q, act_div, shd_div;
  logic            pend;    // shadow holds a value not yet copied to active

  logic            wrap, copy;
  logic [DIVW-1:0] next_div;

  // A RUN channel always has a nonzero active divisor, so act_div-1 never
  // underflows while the comparison matters.
  assign wrap     = (st == RUN) && (q == act_div - DIVW'(1));
  // Idle channels take the shadow at once; running ones only at the wrap so
  // the period in progress completes unchanged.
  assign copy     = pend && ((st == IDLE) || wrap);
  assign next_div = copy ? shd_div : act_div;
  assign busy     = (st == RUN);

  // NOTE: all state here is updated with non-blocking assignments so every
  // decision in this block sees the pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      q        <= '0;
      act_div  <= DIVW'(DEFDIV);
      shd_div  <= DIVW'(DEFDIV);
      act_mode <= CONT;
      shd_mode <= CONT;
      pend     <= 1'b0;
      enb      <= 1'b0;
    end else begin
      // A pulse from this edge's wrap is issued even if stop/align/reload
      // coincide with it.
      enb <= wrap;

      if (copy) begin
        act_div  <= shd_div;
        act_mode <= shd_mode;
      end

      if (ld) begin
        shd_div  <= ld_div;
        shd_mode <= mode_t'(ld_mode);
        pend     <= 1'b1;
      end else if (copy) begin
        pend     <= 1'b0;
      end

      case (st)
        IDLE: begin
          q <= '0;
          // The start check uses the divisor being copied this edge, so a
          // load in the previous cycle is honoured immediately.
          if (start && !stop && (next_div != '0)) st <= RUN;
        end
        RUN: begin
          q <= (wrap || align) ? '0 : q + DIVW'(1);
          if (stop) begin
            st <= IDLE;
            q  <= '0;
          end else if (wrap && ((act_mode == ONESHOT) || (next_div == '0))) begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/clkenb_multi.sv
// clkenb_multi: NCH independent runtime-programmable clock-enable generators.
//   clk, reset : system clock, synchronous active-high reset
//   ld, ld_ch  : load strobe and target channel
//   ld_div     : new divisor (0 disables), ld_mode: 0 continuous / 1 one-shot
//   start/stop : per-channel run / halt requests
//   align      : restart all running counters at 0 together
//   enb        : per-channel single-cycle enables (data enables, not clocks)
//   busy       : per-channel RUN indication
module clkenb_multi
  import clkenb_pkg::*;
#(
  parameter int          NCH    = NCH_DEF,
  parameter int          DIVW   = DIVW_DEF,
  parameter int unsigned DEFDIV = DEFDIV_DEF,
  localparam int         CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld,
  input  logic [CHW-1:0]  ld_ch,
  input  logic [DIVW-1:0] ld_div,
  input  logic            ld_mode,
  input  logic [NCH-1:0]  start,
  input  logic [NCH-1:0]  stop,
  input  logic            align,
  output logic [NCH-1:0]  enb,
  output logic [NCH-1:0]  busy
);

  logic [NCH-1:0] chan_ld;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan_ld[i] = ld && (ld_ch == CHW'(i));

    clkenb_chan #(
      .DIVW   (DIVW),
      .DEFDIV (DEFDIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .ld      (chan_ld[i]),
      .ld_div  (ld_div),
      .ld_mode (ld_mode),
      .start   (start[i]),
      .stop    (stop[i]),
      .align   (align),
      .enb     (enb[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_clkenb_multi.sv
// tb_clkenb_multi: self-checking bench for clkenb_multi. A timestamp-based
// reference model (each running channel knows the absolute edge of its next
// pulse) is compared against the DUT on every cycle; directed table and
// hand-written sequences cover the documented corner cases.
module tb_clkenb_multi;
  import clkenb_pkg::*;

  localparam int          NCH    = 4;
  localparam int unsigned DEFDIV = 12;  // small reset divisor keeps it observable

  logic           clk = 1'b0;
  logic           reset, ld, ld_mode, align;
  logic [1:0]     ld_ch;
  div_t           ld_div;
  logic [NCH-1:0] start, stop, enb, busy;

  int checks = 0;
  int errors = 0;

  clkenb_multi #(.NCH(NCH), .DIVW(DIVW_DEF), .DEFDIV(DEFDIV)) dut (
    .clk(clk), .reset(reset), .ld(ld), .ld_ch(ld_ch), .ld_div(ld_div),
    .ld_mode(ld_mode), .start(start), .stop(stop), .align(align),
    .enb(enb), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          run;
    int unsigned dv, sd;   // active / shadow divisor
    bit          md, smd;  // active / shadow one-shot flag
    bit          pend;
    longint      due;      // edge index whose wrap produces the next pulse
  } mch_t;

  mch_t           m [NCH];
  longint         t = 0;
  logic [NCH-1:0] exp_enb = '0, exp_busy = '0;

  task automatic model_step();
    t++;
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        m[i] = '{run: 0, dv: DEFDIV, sd: DEFDIV, md: 0, smd: 0, pend: 0, due: 0};
        exp_enb[i]  = 1'b0;
        exp_busy[i] = 1'b0;
      end else begin
        bit fire, old_md;
        fire       = m[i].run && (m[i].due == t);
        exp_enb[i] = fire;
        if (m[i].run) begin
          if (fire) begin
            old_md = m[i].md;
            if (m[i].pend) begin
              m[i].dv = m[i].sd; m[i].md = m[i].smd; m[i].pend = 0;
            end
            if (old_md || m[i].dv == 0) m[i].run = 0;
            else                        m[i].due = t + longint'(m[i].dv);
          end else if (align) begin
            m[i].due = t + longint'(m[i].dv);
          end
          if (stop[i]) m[i].run = 0;
        end else begin
          if (m[i].pend) begin
            m[i].dv = m[i].sd; m[i].md = m[i].smd; m[i].pend = 0;
          end
          if (start[i] && !stop[i] && m[i].dv != 0) begin
            m[i].run = 1;
            m[i].due = t + longint'(m[i].dv);
          end
        end
        if (ld && ld_ch == 2'(i)) begin
          m[i].sd = 32'(ld_div); m[i].smd = ld_mode; m[i].pend = 1;
        end
        exp_busy[i] = m[i].run;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge,
  // single-cycle strobes dropped afterwards.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check($sformatf("enb_model@%0d", t),  32'(enb),  32'(exp_enb));
    check($sformatf("busy_model@%0d", t), 32'(busy), 32'(exp_busy));
    ld = 0; start = '0; stop = '0; align = 0;
  endtask

  task automatic load(input int ch, input int unsigned d, input bit md);
    ld = 1; ld_ch = 2'(ch); ld_div = div_t'(d); ld_mode = md;
    tick();
  endtask

  // Ticks until enb[ch] is seen; n = ticks taken, -1 if none within budget.
  task automatic gap(input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (enb[ch]) begin n = k; break; end
    end
  endtask

  typedef struct {
    logic           ld;
    logic [1:0]     ch;
    int unsigned    dv;
    logic [NCH-1:0] start, stop, enb, busy;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int n, f0, f1, cnt;

    reset = 1; ld = 0; ld_ch = '0; ld_div = '0; ld_mode = 0;
    start = '0; stop = '0; align = 0;
    tick(); tick();
    check("reset_enb", 32'(enb), 0);
    check("reset_busy", 32'(busy), 0);
    reset = 0;

    // ---- table: ch0 D=4 continuous, first pulse D+1 edges after start ----
    foreach (tbl[r]) tbl[r] = '{ld: 0, ch: 0, dv: 0, start: '0, stop: '0, enb: '0, busy: '0};
    tbl[0].ld = 1; tbl[0].dv = 4;
    tbl[1].start = 4'b0001;
    for (int r = 1; r <= 13; r++) tbl[r].busy = 4'b0001;
    tbl[5].enb = 4'b0001; tbl[9].enb = 4'b0001; tbl[13].enb = 4'b0001;
    tbl[14].stop = 4'b0001;
    for (int r = 0; r < 16; r++) begin
      ld = tbl[r].ld; ld_ch = tbl[r].ch; ld_div = div_t'(tbl[r].dv); ld_mode = 0;
      start = tbl[r].start; stop = tbl[r].stop;
      tick();
      check($sformatf("tbl_enb[%0d]", r),  32'(enb),  32'(tbl[r].enb));
      check($sformatf("tbl_busy[%0d]", r), 32'(busy), 32'(tbl[r].busy));
    end

    // ---- ch1 D=10, reload D=3 at q=4: period not stretched ----
    load(1, 10, 0);
    start = 4'b0010; tick();
    gap(1, n);
    check("ch1_first_pulse", 32'(n), 10);
    cnt = 0;
    do begin
      if (cnt == 4) begin ld = 1; ld_ch = 2'd1; ld_div = div_t'(3); ld_mode = 0; end
      tick();
      cnt++;
    end while (!enb[1] && cnt < 50);
    check("ch1_reload_period", 32'(cnt), 10);
    gap(1, n); check("ch1_new_period_a", 32'(n), 3);
    gap(1, n); check("ch1_new_period_b", 32'(n), 3);

    // ---- one-shot ch2 D=5 ----
    load(2, 5, 1);
    start = 4'b0100; tick();
    check("oneshot_busy", 32'(busy[2]), 1);
    gap(2, n);
    check("oneshot_latency", 32'(n), 5);
    check("oneshot_busy_drop", 32'(busy[2]), 0);
    cnt = 0;
    repeat (50) begin tick(); if (enb[2]) cnt++; end
    check("oneshot_no_more", 32'(cnt), 0);

    // ---- align: ch0 D=4, ch1 D=6 at arbitrary phase ----
    stop = 4'b0011; tick();
    load(0, 4, 0);
    load(1, 6, 0);
    start = 4'b0001; tick();
    repeat ($urandom_range(0, 5)) tick();
    start = 4'b0010; tick();
    repeat ($urandom_range(0, 7)) tick();
    align = 1; tick();
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (enb[0] && f0 < 0) f0 = k;
      if (enb[1] && f1 < 0) f1 = k;
    end
    check("align_ch0", 32'(f0), 4);
    check("align_ch1", 32'(f1), 6);

    // ---- ch3: start+stop together, then D=0 ----
    load(3, 5, 0);
    start = 4'b1000; stop = 4'b1000; tick();
    check("startstop_busy", 32'(busy[3]), 0);
    cnt = 0;
    repeat (10) begin tick(); if (enb[3]) cnt++; end
    check("startstop_pulses", 32'(cnt), 0);
    load(3, 0, 0);
    start = 4'b1000; tick();
    check("d0_busy", 32'(busy[3]), 0);
    cnt = 0;
    repeat (10) begin tick(); if (enb[3] || busy[3]) cnt++; end
    check("d0_pulses", 32'(cnt), 0);

    // ---- D=1 every cycle, then reset mid-stream with a pending reload ----
    stop = 4'b0001; tick();
    load(0, 1, 0);
    start = 4'b0001; tick();
    cnt = 0;
    repeat (4) begin tick(); if (enb[0]) cnt++; end
    check("d1_every_cycle", 32'(cnt), 4);
    gap(1, n);
    load(1, 2, 0);            // pending on running ch1, must be discarded
    reset = 1; tick();
    check("midreset_enb", 32'(enb), 0);
    check("midreset_busy", 32'(busy), 0);
    reset = 0; tick();
    start = 4'b0011; tick();
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (enb[0] && f0 < 0) f0 = k;
      if (enb[1] && f1 < 0) f1 = k;
    end
    check("postreset_defdiv_ch0", 32'(f0), DEFDIV);
    check("postreset_defdiv_ch1", 32'(f1), DEFDIV);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      ld      = ($urandom_range(0, 7) == 0);
      ld_ch   = 2'($urandom_range(0, 3));
      ld_div  = ($urandom_range(0, 9) == 0) ? div_t'(0) : div_t'($urandom_range(1, 8));
      ld_mode = ($urandom_range(0, 3) == 0);
      start   = 4'($urandom);
      for (int i = 0; i < NCH; i++) stop[i] = ($urandom_range(0, 15) == 0);
      align   = ($urandom_range(0, 30) == 0);
      reset   = ($urandom_range(0, 600) == 0);
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkenb_multi.md
# clkenb_multi

Multi-channel, runtime-programmable clock-enable generator, the parametrised successor to the fixed-frequency single-channel enable generator. It produces NCH independent single-cycle enable pulses from the 100 MHz system clock, with per-channel divisors loaded at run time, continuous or one-shot modes, and a global phase-align input. Consumers are clocked logic on `clk`. Outputs must never drive a clock pin.

## Interface
- NCH, 4, number of channels
- DIVW, 27, divisor width in bits; covers 1 Hz at 100 MHz
- DEFDIV, 100_000_000/100, divisor loaded into every channel at reset

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- ld  in  1  load strobe; writes `ld_div` and `ld_mode` to channel `ld_ch`
- ld_ch  in  $clog2(NCH)  target channel for `ld`
- ld_div  in  DIVW  new divisor D: period of D cycles; D=0 disables the channel
- ld_mode  in  1  0 = continuous, 1 = one-shot
- start  in  NCH  per-channel start (run) request, level-insensitive pulse
- stop  in  NCH  per-channel stop request
- align  in  1  restarts all running channels' counters at 0 together
- enb  out  NCH  enable pulses, one cycle wide
- busy  out  NCH  channel in RUN state

## Operation
- Per-channel state machine with states IDLE and RUN.
  - IDLE -> RUN on `start[i]` when the active divisor is nonzero; the counter clears to 0.
  - RUN -> IDLE on `stop[i]`.
  - In one-shot mode, RUN -> IDLE after the first pulse is issued.
  - `stop` wins over `start` in the same cycle.
- Counter `q` runs 0..D-1 while in RUN.
  - When `q == D-1`: `q` wraps to 0 and `enb[i]` is 1 on the next cycle (registered).
  - Otherwise `enb[i]` is 0.
  - D=1: `enb` is high every cycle in continuous mode.
- Divisor load is double-buffered. `ld` writes a shadow register.
  - Channel IDLE: shadow is copied to active on the next cycle.
  - Channel RUN: copy happens at the wrap (`q == D-1`), so the current period always completes unchanged.
  - `ld` with D=0 to a running channel: the channel goes IDLE at the next wrap; that wrap's pulse is still issued.
  - A second `ld` before the pending copy overwrites the shadow; last write wins.
- `align` clears `q` to 0 in all RUN channels. A wrap coinciding with `align` still issues its pulse.
- `start` on an already running channel is ignored; it does not restart the counter.
- Arithmetic is unsigned, DIVW bits. `q` never exceeds D-1.

## Timing
- Reset values:
  - `enb` = 0, `busy` = 0, all channels IDLE, `q` = 0
  - active and shadow divisor = DEFDIV, mode = continuous
- Latency from `start[i]` (sampled at edge k) to the first `enb[i]` pulse is D+1 edges: `busy` goes high after edge k, and `enb` goes high after edge k+D.
- `stop` sampled at edge k:
  - `busy` is low after edge k.
  - An `enb` pulse already registered at edge k is still visible in that cycle; no further pulses follow.
- `ld` to an IDLE channel: the new divisor is usable by a `start` issued on the following cycle.
- Reset mid-operation clears everything within one edge. Pending shadow loads are discarded.
- Pulse spacing in steady state is exactly D cycles. It is not stretched by `ld`; it is shortened only by `align`.

## Structure
- Package `clkenb_pkg`:
  - `DIVW_DEF`
  - `typedef logic [DIVW-1:0] div_t`
  - `typedef enum logic {IDLE, RUN} chst_t`
  - `typedef enum logic {CONT, ONESHOT} mode_t`
- Sub-module `clkenb_chan`: one channel with counter, FSM and shadow/active divisor. The top level decodes `ld_ch` into a per-channel load strobe and instantiates NCH copies with a generate loop.

## Test plan
- Reset, then `ld` ch0 D=4 continuous, `start[0]` -> `enb[0]` first pulse 5 cycles after start, then every 4 cycles; other channels stay at 0.
- Ch1 running with D=10; `ld` D=3 at `q`=4 -> next pulse still 10 cycles after the previous one, then pulses every 3 cycles.
- One-shot ch2 with D=5, `start` -> exactly one pulse after 6 cycles; `busy[2]` drops with the pulse; no further pulses over 50 cycles.
- Ch0 D=4 and ch1 D=6 both running with arbitrary phase; pulse `align` -> both next pulses land 4 and 6 cycles after `align`, respectively.
- `start` and `stop` on ch3 in the same cycle -> ch3 stays IDLE with no pulses; `ld` D=0 then `start` -> no pulses and `busy` stays 0.
- Ch0 running with D=1, assert `reset` mid-stream -> `enb` = 0 on the next cycle; after release, the active divisor is DEFDIV and the channel is IDLE.
